// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types; instruction-cache frame, address and state.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_NFRAMES = 16;
    localparam int ICACHE_IDXW    = $clog2(ICACHE_NFRAMES);
    localparam int ICACHE_TAGW    = 30 - ICACHE_IDXW;

    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic [1:0]             bytoff;
    } icachef_t;

    typedef struct packed {
        logic                   valid;
        logic [ICACHE_TAGW-1:0] tag;
        word_t                  data;
    } icache_frame_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped read-only instruction cache, one-word blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_dm
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = ICACHE_NFRAMES,
    parameter int CNTW    = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            imemREN,
    input  word_t           imemaddr,
    output logic            ihit,
    output word_t           imemload,
    input  logic            iwait,
    output logic            iREN,
    output word_t           iaddr,
    input  word_t           iload,
    output logic [CNTW-1:0] hit_count,
    output logic [CNTW-1:0] miss_count
);

    localparam int c_idxw = $clog2(NFRAMES);
    localparam int c_tagw = 30 - c_idxw;

    logic [NFRAMES-1:0] r_valid;
    logic [c_tagw-1:0]  r_tag  [NFRAMES];
    word_t              r_data [NFRAMES];
    icache_state_t      r_state;
    logic [29:0]        r_miss_addr;
    logic [CNTW-1:0]    r_hit_count;
    logic [CNTW-1:0]    r_miss_count;

    logic [c_idxw-1:0]  w_req_idx;
    logic [c_tagw-1:0]  w_req_tag;
    logic [c_idxw-1:0]  w_fill_idx;
    logic [c_tagw-1:0]  w_fill_tag;
    icache_state_t      w_next_state;
    logic               w_fill;
    logic               w_unused_bytoff;

    assign w_req_idx       = imemaddr[c_idxw+1:2];
    assign w_req_tag       = imemaddr[31:c_idxw+2];
    assign w_fill_idx      = r_miss_addr[c_idxw-1:0];
    assign w_fill_tag      = r_miss_addr[29:c_idxw];
    assign w_unused_bytoff = ^imemaddr[1:0];

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    always_comb begin
        ihit         = 1'b0;
        imemload     = '0;
        iREN         = 1'b0;
        iaddr        = '0;
        w_fill       = 1'b0;
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (imemREN) begin
                    if (r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag)) begin
                        ihit     = 1'b1;
                        imemload = r_data[w_req_idx];
                    end else begin
                        w_next_state = MISS;
                    end
                end
            end
            MISS: begin
                // The request is never aborted; a redirect is looked up after the fill.
                iREN  = 1'b1;
                iaddr = {r_miss_addr, 2'b00};
                if (!iwait) begin
                    w_fill       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_miss_addr  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && (w_next_state == MISS)) begin
                r_miss_addr <= imemaddr[31:2];
                if (r_miss_count != {CNTW{1'b1}})
                    r_miss_count <= r_miss_count + CNTW'(1);
            end
            if (ihit && (r_hit_count != {CNTW{1'b1}}))
                r_hit_count <= r_hit_count + CNTW'(1);
            // Conflicting lines are simply overwritten; nothing is ever dirty.
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
                r_tag[w_fill_idx]   <= w_fill_tag;
                r_data[w_fill_idx]  <= iload;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the datapath fetch stage (datapath_cache_if icache modport) and the memory controller instruction port.
- Returns hits combinationally and fills one-word blocks on a miss through a two-state FSM.
- Keeps saturating hit/miss counters for the performance dump at halt.

Parameters:
- NFRAMES, 16, number of cache frames; power of two, 2..256.
- CNTW, 32, width of the hit and miss counters.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  datapath fetch address (word_t); bits[1:0] ignored.
- ihit  out  1  instruction valid this cycle.
- imemload  out  32  instruction word (word_t).
- iwait  in  1  memory controller busy; low means iload is valid this cycle.
- iREN  out  1  memory read request.
- iaddr  out  32  memory read address (word_t), word aligned.
- iload  in  32  memory read data (word_t).
- hit_count  out  CNTW  number of hit cycles.
- miss_count  out  CNTW  number of misses started.

Behaviour:
- Address split: byte offset = [1:0]; index = [IDXW+1:2] with IDXW = log2(NFRAMES); tag = [31:IDXW+2].
- Each frame holds valid (1), tag (30-IDXW bits) and data (32 bits).
- Reset (async, nRST=0): every valid bit = 0; state = IDLE; ihit = 0, iREN = 0, iaddr = 0, imemload = 0; both counters = 0. Tag and data contents are don't-care.
- IDLE state:
  - ihit = imemREN & valid[idx] & (tag[idx] == req tag), combinational, zero latency.
  - imemload = data[idx] when ihit = 1; otherwise 0.
  - On imemREN & !hit: latch miss_addr = {imemaddr[31:2], 2'b00}; next state = MISS.
  - imemREN = 0: no state change, ihit = 0.
- MISS state:
  - iREN = 1 and iaddr = miss_addr, held stable until iwait = 0. ihit = 0.
  - The cycle iwait = 0: write frame[miss_addr idx] with valid = 1, tag from miss_addr, data = iload; next state = IDLE.
  - Fill-then-hit: the datapath sees ihit one cycle after the fill, once it re-presents the address. Miss latency = memory latency + 1 cycle.
- imemaddr changes during MISS (branch redirect): the fill still completes for the latched miss_addr; the new address is looked up in IDLE after the fill. The memory request is never aborted.
- imemREN falls during MISS: same rule; the fill completes and the line is installed.
- Fill replaces a valid frame with a different tag (conflict): overwrite unconditionally. No write-back, since the cache is read-only.
- iwait already 0 in the first MISS cycle: fill in that cycle; MISS lasts exactly one cycle.
- Counters:
  - hit_count += 1 on every IDLE cycle with ihit = 1.
  - miss_count += 1 on each IDLE→MISS transition.
  - Both saturate at all-ones.
- No invalidate or flush port; halt is ignored, because the instruction cache never needs write-back.

Decomposition:
- cpu_types_pkg gets:
  - icache_frame_t packed struct {valid, tag, data}.
  - icachef_t address struct {tag, idx, bytoff}.
  - ICACHE_NFRAMES constant.
  - icache_state_t enum {IDLE, MISS}.
- No sub-module. The frame array, FSM and counters live in one always_ff plus one always_comb next-state/output block.
- The top-level caches wrapper instantiates icache_dm next to the dcache and connects it to the datapath_cache_if icache modport and the cache_control_if instruction signals.

Test Plan:
- Cold miss: after reset, imemREN=1, imemaddr=0x0000_0040, iwait high 3 cycles then low with iload=0x2001_0005 → iREN=1 and iaddr=0x40 during MISS, ihit=0 throughout; next IDLE cycle gives ihit=1, imemload=0x2001_0005; miss_count=1, hit_count=1.
- Repeat hit: after the cold miss, read 0x40 for 4 cycles → ihit=1 every cycle, iREN=0, hit_count=5, miss_count unchanged.
- Conflict: with NFRAMES=16, fill 0x40 then 0x80 (same idx 0) with iload=0xDEAD_BEEF → a later read of 0x40 misses again; 0x80 hits with 0xDEAD_BEEF.
- Redirect mid-miss: miss on 0x100, change imemaddr to 0x200 while iwait=1 → iaddr stays 0x100 until iwait=0; frame for 0x100 becomes valid; then a miss for 0x200 starts; miss_count += 2.
- Async reset mid-miss: drop nRST while in MISS → iREN=0, ihit=0 immediately without a clock edge; after release, a read of a previously filled address misses.
- Zero-wait memory: iwait held 0, miss on 0x3C → MISS lasts 1 cycle; ihit=1 on the following cycle.
